// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer pixel packer.
package fb_pkg;
  localparam int          FB_WIDTH     = 720;
  localparam int          FB_HEIGHT    = 480;
  localparam int          STRIDE_WORDS = 90;
  localparam logic [28:0] BASE_WORD    = 29'h06000000;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } fb_entry_t;

  typedef enum logic {WR_IDLE, WR_WAIT} wr_state_t;
endpackage

// File: rtl/fb_word_fifo.sv
// Completed-word FIFO: registered pointers, combinational head; push ignored when full, pop when empty.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fb_entry_t                wr_dat,
  input  logic                     pop,
  output fb_entry_t                rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Power-of-two depth: pointers wrap naturally, the counter separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fb_pixel_packer.sv
// Packs 8bpp pixels into 64-bit DDRAM words: address stage, byte accumulator, word FIFO, req/ack writer.
// px_ready drops when FIFO slots are all claimed; FB_PACKER_DBLBUF_EN enables double buffering.
module fb_pixel_packer #(
  parameter logic [28:0] BASE_WORD    = fb_pkg::BASE_WORD,
  parameter int          STRIDE_WORDS = fb_pkg::STRIDE_WORDS,
  parameter int          FIFO_DEPTH   = 4
`ifdef FB_PACKER_DBLBUF_EN
  , parameter int        BUF_OFFSET_WORDS = 43200
`endif
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [9:0]  px_x,
  input  logic [8:0]  px_y,
  input  logic [7:0]  px_color,
  output logic [28:0] fb_addr,
  output logic [63:0] fb_data,
  output logic [7:0]  fb_be,
  output logic        fb_req,
  input  logic        fb_ready,
  output logic [31:0] fb_base,
  output logic        busy
);
  import fb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ready_en, accept, in_range;
  logic [28:0]   wr_base, px_addr;
  logic          s1_vld, s1_flush;
  logic [28:0]   s1_addr;
  logic [2:0]    s1_lane;
  logic [7:0]    s1_color;
  logic          acc_vld, acc_live, n_acc_vld;
  logic [63:0]   acc_data, n_acc_data;
  logic [7:0]    acc_be, n_acc_be;
  logic [28:0]   acc_addr, n_acc_addr;
  logic          push, pop, issue;
  fb_entry_t     push_dat, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   committed;
  wr_state_t     state, state_n;

`ifdef FB_PACKER_DBLBUF_EN
  logic buf_sel, base_pend;
  // A pixel accepted together with frame_start already belongs to the new buffer.
  assign wr_base = (buf_sel ^ frame_start) ? BASE_WORD + 29'(BUF_OFFSET_WORDS) : BASE_WORD;
`else
  assign wr_base = BASE_WORD;
  assign fb_base = {BASE_WORD, 3'b000};
`endif

  assign in_range = (px_x < 10'(FB_WIDTH)) && (px_y < 9'(FB_HEIGHT));
  assign px_addr  = wr_base + 29'(px_y) * 29'(STRIDE_WORDS) + 29'(px_x[9:3]);
  assign accept   = px_valid & px_ready;

  // frame_start cannot be stalled, so the live accumulator and the in-flight pixel each hold a FIFO slot.
  assign committed = {1'b0, fifo_count} + (CW+1)'(acc_vld) + (CW+1)'(s1_vld);
  assign px_ready  = ready_en & ~fifo_full & (committed < (CW+1)'(FIFO_DEPTH));
  assign busy      = ~fifo_empty | acc_vld | s1_vld | (state == WR_WAIT);
  assign acc_live  = acc_vld & (acc_be != 8'hFF);
  assign push_dat  = '{addr: acc_addr, data: acc_data, be: acc_be};

  always_comb begin
    n_acc_vld  = acc_vld;
    n_acc_data = acc_data;
    n_acc_be   = acc_be;
    n_acc_addr = acc_addr;
    push       = 1'b0;
    if (acc_vld & ~acc_live) begin
      push      = 1'b1;
      n_acc_vld = 1'b0;
    end else if (acc_live & s1_flush) begin
      push      = 1'b1;
      n_acc_vld = 1'b0;
    end
    if (s1_vld) begin
      if (acc_live & ~s1_flush & (s1_addr == acc_addr)) begin
        n_acc_data[{s1_lane, 3'b000} +: 8] = s1_color;
        n_acc_be[s1_lane]                  = 1'b1;
      end else begin
        if (acc_live & ~s1_flush) push = 1'b1;
        n_acc_vld  = 1'b1;
        n_acc_addr = s1_addr;
        n_acc_data = 64'(s1_color) << {s1_lane, 3'b000};
        n_acc_be   = 8'b1 << s1_lane;
      end
    end
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    pop     = 1'b0;
    case (state)
      WR_IDLE: if (!fifo_empty) begin
        issue   = 1'b1;
        state_n = WR_WAIT;
      end
      WR_WAIT: if (fb_ready) begin
        pop     = 1'b1;
        state_n = WR_IDLE;
      end
      default: state_n = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      s1_vld   <= 1'b0;
      s1_flush <= 1'b0;
      s1_addr  <= '0;
      s1_lane  <= '0;
      s1_color <= '0;
      acc_vld  <= 1'b0;
      acc_data <= '0;
      acc_be   <= '0;
      acc_addr <= '0;
      state    <= WR_IDLE;
      fb_req   <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      fb_be    <= '0;
    end else begin
      ready_en <= 1'b1;
      s1_vld   <= accept & in_range;
      s1_flush <= frame_start;
      if (accept) begin
        s1_addr  <= px_addr;
        s1_lane  <= px_x[2:0];
        s1_color <= px_color;
      end
      acc_vld  <= n_acc_vld;
      acc_data <= n_acc_data;
      acc_be   <= n_acc_be;
      acc_addr <= n_acc_addr;
      state    <= state_n;
      fb_req   <= issue;
      if (issue) begin
        fb_addr <= head.addr;
        fb_data <= head.data;
        fb_be   <= head.be;
      end
    end
  end

`ifdef FB_PACKER_DBLBUF_EN
  // fb_base swaps to the finished buffer only after its last words have been acknowledged.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      buf_sel   <= 1'b0;
      base_pend <= 1'b0;
      fb_base   <= {BASE_WORD, 3'b000};
    end else if (frame_start) begin
      buf_sel   <= ~buf_sel;
      base_pend <= 1'b1;
    end else if (base_pend & ~busy) begin
      base_pend <= 1'b0;
      fb_base   <= {(buf_sel ? BASE_WORD : BASE_WORD + 29'(BUF_OFFSET_WORDS)), 3'b000};
    end
  end
`endif

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk_sys),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (push_dat),
    .pop    (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );
endmodule
